// File: rtl/alu_unit_if.sv
// Strobe and operand bundle between the step controller and the ALU stage.
// The controller side is the master; alu_unit is the slave.
interface alu_unit_if #(
  parameter int WIDTH = 10
);
  logic [WIDTH-1:0] Bus;
  logic             Ain;
  logic             Gin;
  logic             Gout;
  logic [3:0]       ALUcont;
  logic [WIDTH-1:0] G;
  logic [3:0]       Flags;

  modport master (
    output Bus, Ain, Gin, Gout, ALUcont,
    input  G, Flags
  );

  modport slave (
    input  Bus, Ain, Gin, Gout, ALUcont,
    output G, Flags
  );
endinterface

// File: rtl/alu_unit.sv
// ALU stage: operand register A, result register G, tristate driver of G onto BusOut.
// Define ALU_FLAGS_EN to build the {Z,N,C,V} status register; otherwise Flags reads 0.
module alu_unit #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  alu_unit_if.slave        bus_if,
  output wire [WIDTH-1:0]  BusOut
);

  typedef enum logic [3:0] {
    OP_PASS0 = 4'b0000,
    OP_PASS1 = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_SUB   = 4'b0011,
    OP_INV   = 4'b0100,
    OP_FLIP  = 4'b0101,
    OP_AND   = 4'b0110,
    OP_OR    = 4'b0111,
    OP_XOR   = 4'b1000,
    OP_LSL   = 4'b1001,
    OP_LSR   = 4'b1010,
    OP_ASR   = 4'b1011
  } alu_op_e;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] flip_b;
  logic [WIDTH-1:0] result;
  logic [3:0]       shamt;

  assign opb   = bus_if.Bus;
  assign shamt = opb[3:0];

  always_comb begin
    flip_b = '0;
    for (int i = 0; i < WIDTH; i++) begin
      flip_b[i] = opb[WIDTH-1-i];
    end
  end

  // Shifts by >= WIDTH fall out of the native operators: zero fill, or sign fill for ASR.
  always_comb begin
    result = '0;
    case (bus_if.ALUcont)
      OP_PASS0, OP_PASS1: result = opb;
      OP_ADD:             result = a_q + opb;
      OP_SUB:             result = a_q - opb;
      OP_INV:             result = ~opb;
      OP_FLIP:            result = flip_b;
      OP_AND:             result = a_q & opb;
      OP_OR:              result = a_q | opb;
      OP_XOR:             result = a_q ^ opb;
      OP_LSL:             result = a_q << shamt;
      OP_LSR:             result = a_q >> shamt;
      OP_ASR:             result = WIDTH'($signed(a_q) >>> shamt);
      default:            result = '0;
    endcase
  end

  always_comb begin
    a_d = bus_if.Ain ? opb : a_q;
    g_d = bus_if.Gin ? result : g_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      g_q <= '0;
    end else begin
      a_q <= a_d;
      g_q <= g_d;
    end
  end

`ifdef ALU_FLAGS_EN
  logic [WIDTH:0] add_ext;
  logic [WIDTH:0] sub_ext;
  logic           c_flag;
  logic           v_flag;
  logic [3:0]     flags_q, flags_d;

  assign add_ext = {1'b0, a_q} + {1'b0, opb};
  assign sub_ext = {1'b0, a_q} - {1'b0, opb};

  always_comb begin
    c_flag = 1'b0;
    v_flag = 1'b0;
    case (bus_if.ALUcont)
      OP_ADD: begin
        c_flag = add_ext[WIDTH];
        v_flag = (a_q[WIDTH-1] == opb[WIDTH-1]) && (result[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        // C is the no-borrow sense: set when A >= B unsigned.
        c_flag = ~sub_ext[WIDTH];
        v_flag = (a_q[WIDTH-1] != opb[WIDTH-1]) && (result[WIDTH-1] != a_q[WIDTH-1]);
      end
      default: begin
        c_flag = 1'b0;
        v_flag = 1'b0;
      end
    endcase
  end

  always_comb begin
    flags_d = flags_q;
    if (bus_if.Gin) begin
      flags_d = {(result == '0), result[WIDTH-1], c_flag, v_flag};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= 4'b0000;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign bus_if.Flags = flags_q;
`else
  assign bus_if.Flags = 4'b0000;
`endif

  assign bus_if.G = g_q;
  // Reset releases the bus at once, regardless of Gout.
  assign BusOut   = (bus_if.Gout && !rst) ? g_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_alu_unit.sv
// Directed table-driven bench for alu_unit plus hand sequences for reset, overlap and tristate.
module tb_alu_unit;

  localparam int W = 10;

  logic         clk;
  logic         rst;
  wire  [W-1:0] BusOut;

  alu_unit_if #(.WIDTH(W)) bif ();

  alu_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bif.slave),
    .BusOut (BusOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    logic [W-1:0] exp_g;
    logic [3:0]   exp_flags;
  } vec_t;

  vec_t vecs [18];

  int n_checks;
  int n_fail;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_released(input string name);
    n_checks++;
    if (!((BusOut === {W{1'bz}}) || (BusOut === {W{1'b0}}))) begin
      n_fail++;
      $display("FAIL %s: BusOut got %h, expected released (z)", name, BusOut);
    end
  endtask

  function automatic logic [3:0] flags_exp(input logic [3:0] f);
`ifdef ALU_FLAGS_EN
    return f;
`else
    return (f & 4'b0000);
`endif
  endfunction

  task automatic idle();
    bif.Ain     = 1'b0;
    bif.Gin     = 1'b0;
    bif.Gout    = 1'b0;
    bif.ALUcont = 4'b0000;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    //          a        b        op       G        {Z,N,C,V}
    vecs[0]  = '{10'h005, 10'h003, 4'b0010, 10'h008, 4'b0000};
    vecs[1]  = '{10'h003, 10'h005, 4'b0011, 10'h3FE, 4'b0100};
    vecs[2]  = '{10'h1FF, 10'h3FF, 4'b0010, 10'h1FE, 4'b0010};
    vecs[3]  = '{10'h200, 10'h002, 4'b1011, 10'h380, 4'b0100};
    vecs[4]  = '{10'h200, 10'h002, 4'b1010, 10'h080, 4'b0000};
    vecs[5]  = '{10'h200, 10'h00C, 4'b1001, 10'h000, 4'b1000};
    vecs[6]  = '{10'h200, 10'h00F, 4'b1011, 10'h3FF, 4'b0100};
    vecs[7]  = '{10'h0AA, 10'h001, 4'b0101, 10'h200, 4'b0100};
    vecs[8]  = '{10'h0AA, 10'h0F0, 4'b0100, 10'h30F, 4'b0100};
    vecs[9]  = '{10'h3C3, 10'h0FF, 4'b0110, 10'h0C3, 4'b0000};
    vecs[10] = '{10'h300, 10'h00F, 4'b0111, 10'h30F, 4'b0100};
    vecs[11] = '{10'h155, 10'h155, 4'b1000, 10'h000, 4'b1000};
    vecs[12] = '{10'h3FF, 10'h123, 4'b0001, 10'h123, 4'b0000};
    vecs[13] = '{10'h3FF, 10'h123, 4'b1100, 10'h000, 4'b1000};
    vecs[14] = '{10'h1FF, 10'h001, 4'b0010, 10'h200, 4'b0101};
    vecs[15] = '{10'h005, 10'h003, 4'b0011, 10'h002, 4'b0010};
    vecs[16] = '{10'h200, 10'h001, 4'b0011, 10'h1FF, 4'b0011};
    vecs[17] = '{10'h300, 10'h3F2, 4'b1010, 10'h0C0, 4'b0000};

    rst     = 1'b1;
    bif.Bus = '0;
    idle();
    repeat (2) @(negedge clk);
    check("reset_G", bif.G, 10'h000);
    check("reset_flags", {6'b0, bif.Flags}, 10'h000);
    check_released("reset_busout");
    rst = 1'b0;

    // Controller sequence: T1 Ain, T2 Gin, T3 Gout.
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      bif.Ain = 1'b1;
      bif.Bus = vecs[i].a;
      @(negedge clk);
      bif.Ain     = 1'b0;
      bif.Gin     = 1'b1;
      bif.Bus     = vecs[i].b;
      bif.ALUcont = vecs[i].op;
      @(negedge clk);
      bif.Gin     = 1'b0;
      bif.ALUcont = 4'b1111;
      bif.Bus     = 10'h2A5;
      bif.Gout    = 1'b1;
      #1;
      check($sformatf("vec%0d_G", i), bif.G, vecs[i].exp_g);
      check($sformatf("vec%0d_flags", i), {6'b0, bif.Flags}, {6'b0, flags_exp(vecs[i].exp_flags)});
      check($sformatf("vec%0d_busout", i), BusOut, vecs[i].exp_g);
      bif.Gout = 1'b0;
    end

    // Hold: no strobes, changing Bus and op leave G and Flags alone.
    @(negedge clk);
    bif.Bus     = 10'h3FF;
    bif.ALUcont = 4'b0010;
    @(negedge clk);
    check("hold_G", bif.G, 10'h0C0);
    check("hold_flags", {6'b0, bif.Flags}, 10'h000);

    // Ain and Gin together: G uses old A, A takes Bus in parallel.
    @(negedge clk);
    bif.Ain = 1'b1;
    bif.Bus = 10'h010;
    @(negedge clk);
    bif.Gin     = 1'b1;
    bif.Bus     = 10'h001;
    bif.ALUcont = 4'b0010;
    @(negedge clk);
    bif.Ain = 1'b0;
    check("overlap_G", bif.G, 10'h011);
    bif.Bus = 10'h000;
    @(negedge clk);
    bif.Gin = 1'b0;
    check("overlap_newA", bif.G, 10'h001);

    // Tristate with Gout low while G is nonzero.
    check_released("gout0_busout");

    // Gout across a Gin edge: old G this cycle, new G after the edge.
    bif.Gout    = 1'b1;
    bif.Gin     = 1'b1;
    bif.ALUcont = 4'b0000;
    bif.Bus     = 10'h2AA;
    #1;
    check("gout_gin_old", BusOut, 10'h001);
    @(negedge clk);
    bif.Gin = 1'b0;
    #1;
    check("gout_gin_new", BusOut, 10'h2AA);

    // Load a nonzero A and flagged G, then reset asynchronously mid-cycle.
    @(negedge clk);
    bif.Gout    = 1'b0;
    bif.Ain     = 1'b1;
    bif.Bus     = 10'h003;
    @(negedge clk);
    bif.Ain     = 1'b0;
    bif.Gin     = 1'b1;
    bif.Bus     = 10'h005;
    bif.ALUcont = 4'b0011;
    @(negedge clk);
    bif.Gin  = 1'b0;
    bif.Gout = 1'b1;
    #1;
    check("presreset_G", bif.G, 10'h3FE);
    #1;
    rst = 1'b1;
    #1;
    check("async_reset_G", bif.G, 10'h000);
    check("async_reset_flags", {6'b0, bif.Flags}, 10'h000);
    check_released("async_reset_busout");
    @(negedge clk);
    rst         = 1'b0;
    bif.Gout    = 1'b0;
    bif.Gin     = 1'b1;
    bif.Bus     = 10'h007;
    bif.ALUcont = 4'b0010;
    @(negedge clk);
    bif.Gin = 1'b0;
    check("post_reset_A_zero", bif.G, 10'h007);

    // Gin low with any op: no capture.
    bif.ALUcont = 4'b0100;
    bif.Bus     = 10'h000;
    @(negedge clk);
    check("gin_low_no_capture", bif.G, 10'h007);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
# alu_unit

Arithmetic/logic stage of the 10-bit processor datapath. It sits downstream of the step controller and consumes that controller's `Ain`, `Gin`, `Gout` and `ALUcont` strobes. It holds operand register A and result register G. It computes a 10-bit result from A and the shared data bus, and drives G back onto the bus when told to.

## Interface
- `WIDTH`, default 10: datapath width. Only 10 is supported.
- `clk`, input, 1: single system clock; all registers update on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `Bus`, input, `WIDTH`: shared data bus, read as operand A source and operand B.
- `Ain`, input, 1: capture `Bus` into A at the next edge.
- `Gin`, input, 1: capture ALU result (and flags) into G at the next edge.
- `Gout`, input, 1: drive G onto `BusOut`.
- `ALUcont`, input, 4: operation select; sampled only when `Gin`=1.
- `BusOut`, output, `WIDTH`: equals G when `Gout`=1, high-Z otherwise.
- `G`, output, `WIDTH`: G register contents (debug/display).
- `Flags`, output, 4: {Z,N,C,V} status register.

## Operation
- Operands: A is the registered A value; B is the live `Bus`.
- Result by `ALUcont` (all arithmetic mod 2^10):
  - 0000, 0001: B (pass-through).
  - 0010 ADD: A+B.
  - 0011 SUB: A−B.
  - 0100 INV: ~B.
  - 0101 FLIP: bit-reverse of B (bit i ← bit 9−i).
  - 0110 AND: A&B.
  - 0111 OR: A|B.
  - 1000 XOR: A^B.
  - 1001 LSL: A << B[3:0].
  - 1010 LSR: A >> B[3:0], logical.
  - 1011 ASR: A >> B[3:0], arithmetic.
  - 1100–1111: 0.
- Shift amount: B[3:0], range 0–15. Amounts ≥10 give 0 for LSL/LSR and 10 copies of A[9] for ASR. B[9:4] is ignored.
- Flags (only with macro): Z = result==0 and N = result[9], for every op.
  - ADD: C = carry out of bit 9; V = signed overflow.
  - SUB: C = no-borrow (A ≥ B unsigned); V = signed overflow.
  - All other ops: C = 0, V = 0.
- `ALUcont` containing X/Z while `Gin`=0 has no effect.

## Timing
- Reset: A=0, G=0, Flags=0, `BusOut`=Z. Reset takes effect immediately, including mid-instruction. The first edge after deassertion follows the normal rules.
- `Ain`=1 at edge k: A = `Bus` sampled at edge k.
- `Gin`=1 at edge k: G = f(A before edge k, `Bus` at edge k). One-cycle latency.
  - `Ain` and `Gin` asserted in the same cycle: G uses the old A; A loads `Bus` in parallel.
- `Gout`: `BusOut` is purely combinational from G, so it is valid in the same cycle `Gout` rises.
  - `Gout`=1 and `Gin`=1 together: `BusOut` shows the old G that cycle; G updates at the edge.
- No strobe asserted: A, G and Flags hold.
- Controller sequence: T1 `Ain`, T2 `Gin`, T3 `Gout`. The result reaches the bus in T3, two edges after A was loaded.

## Configuration
- `ALU_FLAGS_EN` defined: the Flags register is implemented and updated with G on `Gin`.
- `ALU_FLAGS_EN` undefined: no flag logic; `Flags` is tied to 4'b0000. The port list is unchanged.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → A=0, G=0, Flags=0 and `BusOut`=Z immediately, before any clock edge.
- ADD: `Ain` with Bus=0x005, then `Gin` with Bus=0x003 and ALUcont=0010, then `Gout` → BusOut=0x008, Flags={0,0,0,0}.
- SUB borrow: A=0x003, B=0x005, SUB → G=0x3FE, Flags Z=0, N=1, C=0, V=0.
  - A=0x1FF, B=0x3FF, ADD → G=0x1FE, C=1, V=0.
- Shifts, with A=0x200:
  - ASR by 2 → 0x380.
  - LSR by 2 → 0x080.
  - LSL by 12 → 0x000, Z=1.
  - ASR by 15 → 0x3FF.
- Overlap and tristate:
  - `Ain`+`Gin` in the same cycle with A=0x010, Bus=0x001, ADD → G=0x011 and A=0x001.
  - `Gout`=0 → BusOut=Z.
  - `Gout` during a `Gin` edge → old G shown, new G next cycle.
- Macro off: rerun the SUB test → Flags stays 0000 and G is unchanged.
